// File: rtl/mips_data_bus.sv
// Data-side bus for the multicycle MIPS core: word RAM plus a memory-mapped
// 8N1 UART transmitter with a byte FIFO and a saturating dropped-byte counter.
module mips_data_bus #(
  parameter int MEM_WORDS  = 4096,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        uart_tx
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Address decode on word index; byte-lane bits are don't-care.
  logic [29:0] widx;
  logic        is_ram, is_data, is_stat, is_drop, unused_addr;
  assign widx        = Address[31:2];
  assign unused_addr = ^Address[1:0];
  assign is_ram      = (Address[31:AW+2] == '0);
  assign is_data     = (widx == 30'h0400_0000);
  assign is_stat     = (widx == 30'h0400_0001);
  assign is_drop     = (widx == 30'h0400_0002);

  logic we;
  assign we = MemWrite & rst;

  logic [31:0] mem [MEM_WORDS];
  always_ff @(posedge clk)
    if (we && is_ram) mem[Address[AW+1:2]] <= Write_data;

  // TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   occ;
  logic          full, empty, push, pop, push_req, drop_ev, drop_clr;
  logic [31:0]   drop_cnt;

  assign full     = (occ == (PW+1)'(FIFO_DEPTH));
  assign empty    = (occ == '0);
  assign push_req = we & is_data;
  assign push     = push_req & ~full;
  assign drop_ev  = push_req & full;
  assign drop_clr = we & is_drop;

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= Write_data[7:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // A drop coinciding with a clear counts as the first drop after the clear.
  always_ff @(posedge clk) begin
    if (!rst)          drop_cnt <= '0;
    else if (drop_ev)  drop_cnt <= drop_clr ? 32'd1 : (&drop_cnt ? drop_cnt : drop_cnt + 1'b1);
    else if (drop_clr) drop_cnt <= '0;
  end

  // TX FSM
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          bit_end, busy;

  assign bit_end = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      shift   <= shift_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_idx;
    shift_nx = shift;
    pop      = 1'b0;
    case (state)
      IDLE:
        if (!empty) begin
          pop      = 1'b1;
          shift_nx = fifo_mem[rd_ptr];
          cnt_nx   = '0;
          state_nx = START;
        end
      START:
        if (bit_end) begin
          cnt_nx   = '0;
          bit_nx   = '0;
          state_nx = DATA;
        end else cnt_nx = cnt + 1'b1;
      DATA:
        if (bit_end) begin
          cnt_nx   = '0;
          shift_nx = shift >> 1;
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_nx   = bit_idx + 1'b1;
        end else cnt_nx = cnt + 1'b1;
      STOP:
        if (bit_end) begin
          cnt_nx = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop      = 1'b1;
            shift_nx = fifo_mem[rd_ptr];
            state_nx = START;
          end else state_nx = IDLE;
        end else cnt_nx = cnt + 1'b1;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    busy    = (state != IDLE);
    case (state)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = shift[0];
      default: uart_tx = 1'b1;
    endcase
  end

  logic [31:0] stat_word;
  always_comb begin
    stat_word           = '0;
    stat_word[0]        = full;
    stat_word[1]        = empty;
    stat_word[2]        = busy;
    stat_word[8 +: PW+1] = occ;
  end

  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      if (is_ram)       Read_data = mem[Address[AW+1:2]];
      else if (is_stat) Read_data = stat_word;
      else if (is_drop) Read_data = drop_cnt;
    end
  end
endmodule

// File: tb/tb_mips_data_bus.sv
// Directed bench for mips_data_bus: RAM, UART framing, FIFO overflow/drop
// counting, unmapped accesses and mid-frame reset.
module tb_mips_data_bus;
  localparam logic [31:0] UDATA = 32'h1000_0000;
  localparam logic [31:0] USTAT = 32'h1000_0004;
  localparam logic [31:0] UDROP = 32'h1000_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Address = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Write_data = '0;
  logic [31:0] Read_data;
  logic        uart_tx;

  int cmps = 0;
  int errs = 0;

  mips_data_bus #(.MEM_WORDS(4096), .FIFO_DEPTH(16), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .Address(Address), .MemRead(MemRead),
    .MemWrite(MemWrite), .Write_data(Write_data), .Read_data(Read_data),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Address = a; Write_data = d; MemWrite = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Address = a; MemRead = 1'b1;
    #1 d = Read_data;
    MemRead = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cmps++; if (uart_tx !== 1'b1) begin errs++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    bus_read(USTAT, r);
    cmps++; if (r !== 32'h2) begin errs++; $display("FAIL reset_stat got %h want 00000002", r); end
    bus_read(UDROP, r);
    cmps++; if (r !== 32'h0) begin errs++; $display("FAIL reset_drop got %h want 0", r); end
    Address = USTAT; MemRead = 1'b0; #1;
    cmps++; if (Read_data !== 32'h0) begin errs++; $display("FAIL reset_rd_idle got %h want 0", Read_data); end
    rst = 1'b1;
  endtask

  task automatic test_ram;
    logic [31:0] r;
    bus_write(32'h10, 32'h1234_5678);
    bus_write(32'h3FFC, 32'hCAFE_F00D);
    bus_read(32'h10, r);
    cmps++; if (r !== 32'h1234_5678) begin errs++; $display("FAIL ram_rd got %h want 12345678", r); end
    bus_read(32'h13, r);
    cmps++; if (r !== 32'h1234_5678) begin errs++; $display("FAIL ram_rd_bytelane got %h want 12345678", r); end
    Address = 32'h10; MemRead = 1'b0; #1;
    cmps++; if (Read_data !== 32'h0) begin errs++; $display("FAIL ram_memread0 got %h want 0", Read_data); end
    bus_read(32'h3FFC, r);
    cmps++; if (r !== 32'hCAFE_F00D) begin errs++; $display("FAIL ram_last_word got %h want cafef00d", r); end
    bus_read(32'h4010, r);
    cmps++; if (r !== 32'h0) begin errs++; $display("FAIL ram_out_of_range got %h want 0", r); end
    bus_read(UDATA, r);
    cmps++; if (r !== 32'h0) begin errs++; $display("FAIL udata_read got %h want 0", r); end
  endtask

  task automatic test_uart_frame;
    logic [7:0]  byte_v = 8'hA5;
    logic [31:0] r;
    logic        exp;
    int          bad_tx = 0, bad_busy = 0;
    bus_write(UDATA, {24'h0, byte_v});
    cmps++; if (uart_tx !== 1'b1) begin errs++; $display("FAIL frame_pre_start got %b want 1", uart_tx); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k / 4 == 0)      exp = 1'b0;
      else if (k / 4 == 9) exp = 1'b1;
      else                 exp = byte_v[k/4 - 1];
      if (uart_tx !== exp) bad_tx++;
      bus_read(USTAT, r);
      if (r[2] !== 1'b1) bad_busy++;
    end
    cmps++; if (bad_tx != 0) begin errs++; $display("FAIL frame_a5_wave got %0d bad samples want 0", bad_tx); end
    cmps++; if (bad_busy != 0) begin errs++; $display("FAIL frame_busy got %0d not-busy samples want 0", bad_busy); end
    @(negedge clk);
    bus_read(USTAT, r);
    cmps++; if (uart_tx !== 1'b1 || r !== 32'h2) begin errs++; $display("FAIL frame_idle_after got tx=%b stat=%h want tx=1 stat=00000002", uart_tx, r); end
  endtask

  task automatic test_fifo_fill;
    logic        wave [0:689];
    logic [31:0] r;
    logic [7:0]  bv;
    logic        exp;
    int          bad;
    for (int n = 0; n < 690; n++) begin
      @(negedge clk);
      wave[n] = uart_tx;
      if (n < 20) begin
        Address = UDATA; Write_data = n; MemWrite = 1'b1;
      end else if (n == 20) begin
        MemWrite = 1'b0;
        bus_read(USTAT, r);
        cmps++; if (r !== 32'h0000_1005) begin errs++; $display("FAIL fill_stat got %h want 00001005", r); end
        bus_read(UDROP, r);
        cmps++; if (r !== 32'd3) begin errs++; $display("FAIL fill_drop got %0d want 3", r); end
      end else if (n == 21) begin
        Address = UDROP; Write_data = 32'hFFFF; MemWrite = 1'b1;
      end else if (n == 22) begin
        MemWrite = 1'b0;
        bus_read(UDROP, r);
        cmps++; if (r !== 32'd0) begin errs++; $display("FAIL drop_clear got %0d want 0", r); end
      end else if (n == 23) begin
        Address = UDATA; Write_data = 32'h77; MemWrite = 1'b1;
      end else if (n == 24) begin
        MemWrite = 1'b0;
        bus_read(UDROP, r);
        cmps++; if (r !== 32'd1) begin errs++; $display("FAIL drop_after_clear got %0d want 1", r); end
        bus_read(USTAT, r);
        cmps++; if (r !== 32'h0000_1005) begin errs++; $display("FAIL full_stat_hold got %h want 00001005", r); end
      end
    end
    // Bytes 0..16 accepted; frames start at sample 2 and repeat every 40 cycles.
    for (int f = 0; f < 17; f++) begin
      bv  = f[7:0];
      bad = 0;
      for (int k = 0; k < 40; k++) begin
        if (k / 4 == 0)      exp = 1'b0;
        else if (k / 4 == 9) exp = 1'b1;
        else                 exp = bv[k/4 - 1];
        if (wave[2 + 40*f + k] !== exp) bad++;
      end
      cmps++; if (bad != 0) begin errs++; $display("FAIL b2b_frame%0d got %0d bad samples want 0", f, bad); end
    end
    bad = 0;
    for (int n = 682; n < 690; n++) if (wave[n] !== 1'b1) bad++;
    cmps++; if (bad != 0) begin errs++; $display("FAIL b2b_tail_idle got %0d low samples want 0", bad); end
    bus_read(USTAT, r);
    cmps++; if (r !== 32'h2) begin errs++; $display("FAIL drained_stat got %h want 00000002", r); end
  endtask

  task automatic test_unmapped;
    logic [31:0] r;
    bus_read(32'h2000_0000, r);
    cmps++; if (r !== 32'h0) begin errs++; $display("FAIL unmapped_rd got %h want 0", r); end
    bus_write(32'h2000_0000, 32'hDEAD_BEEF);
    bus_read(USTAT, r);
    cmps++; if (r !== 32'h2) begin errs++; $display("FAIL unmapped_wr_fifo got stat %h want 00000002", r); end
    bus_write(32'h2000_0010, 32'hDEAD_BEEF);
    bus_write(USTAT, 32'hFFFF_FFFF);
    bus_read(32'h10, r);
    cmps++; if (r !== 32'h1234_5678) begin errs++; $display("FAIL unmapped_wr_ram got %h want 12345678", r); end
    bus_read(USTAT, r);
    cmps++; if (r !== 32'h2) begin errs++; $display("FAIL stat_wr_ignored got %h want 00000002", r); end
    bus_read(UDROP, r);
    cmps++; if (r !== 32'd1) begin errs++; $display("FAIL unmapped_wr_drop got %0d want 1", r); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] r;
    int          bad = 0;
    bus_write(UDATA, 32'h3C);
    repeat (12) @(negedge clk);
    cmps++; if (uart_tx !== 1'b0) begin errs++; $display("FAIL midframe_pre got %b want 0", uart_tx); end
    rst = 1'b0; Address = 32'h10; Write_data = 32'h0; MemWrite = 1'b1;
    @(negedge clk);
    rst = 1'b1; MemWrite = 1'b0;
    cmps++; if (uart_tx !== 1'b1) begin errs++; $display("FAIL midreset_tx got %b want 1", uart_tx); end
    bus_read(USTAT, r);
    cmps++; if (r !== 32'h2) begin errs++; $display("FAIL midreset_stat got %h want 00000002", r); end
    bus_read(UDROP, r);
    cmps++; if (r !== 32'h0) begin errs++; $display("FAIL midreset_drop got %0d want 0", r); end
    bus_read(32'h10, r);
    cmps++; if (r !== 32'h1234_5678) begin errs++; $display("FAIL midreset_ram got %h want 12345678", r); end
    repeat (8) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    cmps++; if (bad != 0) begin errs++; $display("FAIL midreset_line_high got %0d low samples want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_uart_frame();
    test_fifo_fill();
    test_unmapped();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
